// File: rtl/cw_decode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cw_decode_ctrl: frame sequencer for the constant-weight decoder top.     |
// | Loads NUM_CW codewords, fires the decoder, packs its bits into words.    |
// | Optional watchdog: define CW_DECODE_CTRL_TIMEOUT_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cw_decode_ctrl #(
    parameter int CW_W    = 20,
    parameter int NUM_CW  = 10,
    parameter int OUT_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             frame_go,
    input  logic [CW_W-1:0]  cw_data,
    input  logic             cw_valid,
    output logic             cw_ready,
    output logic [CW_W-1:0]  fifo_din,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    output logic             dec_start,
    input  logic             dec_bit,
    input  logic             dec_rdy,
    input  logic             dec_done,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             err_ovf,
    output logic             err_timeout
);

    localparam int CNT_W = $clog2(NUM_CW + 1);
    localparam int BIT_W = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] LAST_CW  = CNT_W'(NUM_CW - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(OUT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cw_cnt_q, cw_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [OUT_W-1:0] shreg_q, shreg_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             dec_start_q, dec_start_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q;
    logic             err_ovf_q, err_ovf_d;
    logic             push_en;
    logic [OUT_W-1:0] push_word;
    logic             room;

`ifdef CW_DECODE_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] TMO_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_timeout_q, err_timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
`endif

    // Holding register can take a new word if empty or being drained now.
    assign room = ~out_valid_q | out_ready;

    always_comb begin
        state_d      = state_q;
        cw_cnt_d     = cw_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q & ~out_ready;
        dec_start_d  = 1'b0;
        frame_done_d = 1'b0;
        err_ovf_d    = err_ovf_q;
        push_en      = 1'b0;
        push_word    = '0;
        cw_ready     = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_din     = '0;
`ifdef CW_DECODE_CTRL_TIMEOUT_EN
        wd_d          = wd_q;
        err_timeout_d = err_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_go) begin
                    state_d   = S_LOAD;
                    cw_cnt_d  = '0;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    err_ovf_d = 1'b0;
`ifdef CW_DECODE_CTRL_TIMEOUT_EN
                    err_timeout_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                cw_ready = ~fifo_full;
                if (cw_valid && !fifo_full) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = cw_data;
                    cw_cnt_d   = cw_cnt_q + 1'b1;
                    if (cw_cnt_q == LAST_CW) begin
                        state_d     = S_START;
                        dec_start_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
`ifdef CW_DECODE_CTRL_TIMEOUT_EN
                wd_d = '0;
`endif
            end
            S_RUN: begin
                if (dec_rdy) begin
                    shreg_d = {shreg_q[OUT_W-2:0], dec_bit};
                    if (bit_cnt_q == LAST_BIT) begin
                        push_en   = 1'b1;
                        push_word = {shreg_q[OUT_W-2:0], dec_bit};
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
`ifdef CW_DECODE_CTRL_TIMEOUT_EN
                wd_d = wd_q + 1'b1;
`endif
                if (dec_done) begin
                    state_d = S_FLUSH;
                end
`ifdef CW_DECODE_CTRL_TIMEOUT_EN
                else if (wd_q == TMO_LAST) begin
                    err_timeout_d = 1'b1;
                    bit_cnt_d     = '0;
                    state_d       = S_DONE;
                end
`endif
            end
            S_FLUSH: begin
                // Only the low bit_cnt bits are live; shift them up to the MSB.
                if (bit_cnt_q != '0) begin
                    push_en   = 1'b1;
                    push_word = shreg_q << (OUT_W - int'(bit_cnt_q));
                end
                bit_cnt_d = '0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_en) begin
            if (room) begin
                out_data_d  = push_word;
                out_valid_d = 1'b1;
            end else begin
                err_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= S_IDLE;
            cw_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            dec_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cw_cnt_q     <= cw_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            dec_start_q  <= dec_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= (state_d != S_IDLE);
            err_ovf_q    <= err_ovf_d;
        end
    end

`ifdef CW_DECODE_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign dec_start  = dec_start_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign err_ovf    = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cw_decode_ctrl.sv
`default_nettype none
// Bench for cw_decode_ctrl: frame-level reference model checked every cycle,
// plus literal expectations per directed scenario.
module tb_cw_decode_ctrl;

    localparam int CW_W    = 20;
    localparam int NUM_CW  = 10;
    localparam int OUT_W   = 8;
    localparam int TIMEOUT = 64;
`ifdef CW_DECODE_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_RUN = 3, P_FLUSH = 4, P_DONE = 5;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             frame_go = 1'b0;
    logic [CW_W-1:0]  cw_data = '0;
    logic             cw_valid = 1'b0;
    logic             cw_ready;
    logic [CW_W-1:0]  fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full = 1'b0;
    logic             dec_start;
    logic             dec_bit = 1'b0;
    logic             dec_rdy = 1'b0;
    logic             dec_done = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             frame_done;
    logic             err_ovf;
    logic             err_timeout;

    always #5 clk = ~clk;

    cw_decode_ctrl #(
        .CW_W(CW_W), .NUM_CW(NUM_CW), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_b(rst_b), .frame_go(frame_go),
        .cw_data(cw_data), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .dec_start(dec_start), .dec_bit(dec_bit), .dec_rdy(dec_rdy), .dec_done(dec_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .err_ovf(err_ovf), .err_timeout(err_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phase, codeword count, bit accumulator as an integer.
    int       ph;
    int       m_cnt, m_acc, m_n, m_wd;
    bit       m_hv, m_start, m_fdone, m_ovf, m_tmo;
    logic [7:0] m_hd;

    task automatic model_reset();
        ph = P_IDLE; m_cnt = 0; m_acc = 0; m_n = 0; m_wd = 0;
        m_hv = 0; m_hd = 8'h00; m_start = 0; m_fdone = 0; m_ovf = 0; m_tmo = 0;
    endtask

    task automatic model_step();
        bit         room;
        bit         hv_n;
        logic [7:0] hd_n;
        int         word;
        room = !m_hv || out_ready;
        hv_n = m_hv && !out_ready;
        hd_n = m_hd;
        word = -1;
        m_start = 0;
        m_fdone = 0;
        case (ph)
            P_IDLE: if (frame_go) begin
                ph = P_LOAD; m_cnt = 0; m_acc = 0; m_n = 0; m_ovf = 0; m_tmo = 0;
            end
            P_LOAD: if (cw_valid && !fifo_full) begin
                m_cnt++;
                if (m_cnt == NUM_CW) begin ph = P_START; m_start = 1; end
            end
            P_START: begin ph = P_RUN; m_wd = 0; end
            P_RUN: begin
                if (dec_rdy) begin
                    m_acc = m_acc * 2 + int'(dec_bit);
                    m_n++;
                    if (m_n == OUT_W) begin word = m_acc; m_acc = 0; m_n = 0; end
                end
                m_wd++;
                if (dec_done) ph = P_FLUSH;
                else if (TMO_EN && m_wd == TIMEOUT) begin
                    m_tmo = 1; m_acc = 0; m_n = 0; ph = P_DONE;
                end
            end
            P_FLUSH: begin
                if (m_n > 0) word = m_acc * (1 << (OUT_W - m_n));
                m_acc = 0; m_n = 0; ph = P_DONE;
            end
            P_DONE: if (!m_hv) begin m_fdone = 1; ph = P_IDLE; end
            default: ph = P_IDLE;
        endcase
        if (word >= 0) begin
            if (room) begin hv_n = 1; hd_n = 8'(word); end
            else m_ovf = 1;
        end
        m_hv = hv_n;
        m_hd = hd_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_b);
            if (!rst_b) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare and transaction monitors.
    logic [7:0] rx[$];
    int n_wr = 0, n_start = 0, n_fdone = 0;

    initial begin
        bit              exp_rdy;
        bit              exp_wr;
        logic [CW_W-1:0] exp_din;
        forever begin
            @(negedge clk);
            exp_rdy = (ph == P_LOAD) && !fifo_full;
            exp_wr  = exp_rdy && cw_valid;
            exp_din = exp_wr ? cw_data : '0;
            check("cw_ready",    32'(cw_ready),    32'(exp_rdy));
            check("fifo_wr_en",  32'(fifo_wr_en),  32'(exp_wr));
            check("fifo_din",    32'(fifo_din),    32'(exp_din));
            check("dec_start",   32'(dec_start),   32'(m_start));
            check("out_valid",   32'(out_valid),   32'(m_hv));
            check("out_data",    32'(out_data),    32'(m_hd));
            check("busy",        32'(busy),        32'(ph != P_IDLE));
            check("frame_done",  32'(frame_done),  32'(m_fdone));
            check("err_ovf",     32'(err_ovf),     32'(m_ovf));
            check("err_timeout", 32'(err_timeout), 32'(m_tmo));
            if (rst_b && out_valid && out_ready) rx.push_back(out_data);
            if (fifo_wr_en) n_wr++;
            if (dec_start) n_start++;
            if (frame_done) n_fdone++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        rx.delete();
        n_wr = 0; n_start = 0; n_fdone = 0;
    endtask

    function automatic logic bitval(input int mode, input int k);
        logic [7:0] p;
        p = 8'h5A;
        case (mode)
            0:       return (k % 2 == 0);
            1:       return 1'b1;
            default: return p[7 - (k % 8)];
        endcase
    endfunction

    // Accept frame_go, push NUM_CW codewords; optionally hold fifo_full for
    // stall_len cycles once stall_after writes have happened.
    task automatic start_frame(input int stall_after, input int stall_len);
        int i = 0;
        int guard = 0;
        int stall = 0;
        bit stalled = 0;
        bit just_freed = 0;
        bit wrote;
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        while (i < NUM_CW && guard < 300) begin
            guard++;
            if (!stalled && i == stall_after && stall_len > 0) begin
                stall = stall_len; stalled = 1;
            end
            cw_valid  = 1'b1;
            cw_data   = CW_W'(32'h1111 * (i + 1) + 7);
            fifo_full = (stall > 0);
            @(negedge clk);
            wrote = fifo_wr_en;
            if (stall > 0) begin
                check("stall_no_write", 32'(wrote), 32'd0);
                stall--;
                just_freed = (stall == 0);
            end else if (just_freed) begin
                check("write_on_full_drop", 32'(wrote), 32'd1);
                just_freed = 0;
            end
            step();
            if (wrote) i++;
        end
        cw_valid  = 1'b0;
        fifo_full = 1'b0;
        check("load_complete", 32'(i), 32'(NUM_CW));
        @(negedge clk);
        check("dec_start_latency", 32'(dec_start), 32'd1);
        step();
    endtask

    task automatic run_bits(input int n, input int mode, input bit simul);
        for (int k = 0; k < n; k++) begin
            dec_rdy  = 1'b1;
            dec_bit  = bitval(mode, k);
            dec_done = simul && (k == n - 1);
            step();
        end
        dec_rdy = 1'b0; dec_bit = 1'b0; dec_done = 1'b0;
    endtask

    task automatic finish_frame(input bit send_done);
        int guard = 0;
        if (send_done) begin
            dec_done = 1'b1;
            step();
            dec_done = 1'b0;
        end
        while (n_fdone == 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        step();
        step();
        check("frame_done_once", 32'(n_fdone), 32'd1);
    endtask

    initial begin
        int n_aa;
        // Reset state
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out",  32'({out_valid, out_data}), 32'd0);
        rst_b = 1'b1;
        step();

        // Basic frame: 80 alternating bits -> ten 0xAA words
        out_ready = 1'b1;
        clear_counts();
        start_frame(-1, 0);
        run_bits(80, 0, 1'b0);
        finish_frame(1'b1);
        n_aa = 0;
        foreach (rx[j]) if (rx[j] == 8'hAA) n_aa++;
        check("basic_words", 32'(rx.size()), 32'd10);
        check("basic_aa",    32'(n_aa), 32'd10);
        check("basic_wr",    32'(n_wr), 32'd10);
        check("basic_start", 32'(n_start), 32'd1);
        check("basic_ovf",   32'(err_ovf), 32'd0);

        // Backpressure on load; dec_done together with the 8th bit
        clear_counts();
        start_frame(3, 5);
        run_bits(8, 2, 1'b1);
        finish_frame(1'b0);
        check("bp_wr",    32'(n_wr), 32'd10);
        check("simul_n",  32'(rx.size()), 32'd1);
        check("simul_w",  32'(rx.size() > 0 ? rx[0] : 8'h00), 32'h5A);

        // Partial flush: 12 ones -> FF, F0
        clear_counts();
        start_frame(-1, 0);
        run_bits(12, 1, 1'b0);
        finish_frame(1'b1);
        check("part_n",  32'(rx.size()), 32'd2);
        check("part_w0", 32'(rx.size() > 0 ? rx[0] : 8'h00), 32'hFF);
        check("part_w1", 32'(rx.size() > 1 ? rx[1] : 8'h00), 32'hF0);

        // Overflow with out_ready low; frame_go held while busy
        out_ready = 1'b0;
        clear_counts();
        start_frame(-1, 0);
        frame_go = 1'b1;
        run_bits(15, 1, 1'b0);
        @(negedge clk);
        check("ovf_before", 32'(err_ovf), 32'd0);
        step();
        dec_rdy = 1'b1; dec_bit = 1'b1;
        step();
        dec_rdy = 1'b0; dec_bit = 1'b0;
        @(negedge clk);
        check("ovf_flag",  32'(err_ovf), 32'd1);
        check("ovf_hold",  32'({out_valid, out_data}), 32'h1FF);
        check("ovf_busy",  32'(busy), 32'd1);
        step();
        frame_go  = 1'b0;
        out_ready = 1'b1;
        finish_frame(1'b1);
        check("ovf_rx_n", 32'(rx.size()), 32'd1);
        check("ovf_rx_w", 32'(rx.size() > 0 ? rx[0] : 8'h00), 32'hFF);

        // Reset mid-RUN
        clear_counts();
        start_frame(-1, 0);
        run_bits(3, 1, 1'b0);
        rst_b = 1'b0;
        #1;
        check("mid_rst_regs", 32'({busy, out_valid, dec_start, frame_done, err_ovf, err_timeout}), 32'd0);
        check("mid_rst_comb", 32'({cw_ready, fifo_wr_en}), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        step();
        step();
        rst_b = 1'b1;
        step();

        // Watchdog: no dec_done at all
        clear_counts();
        start_frame(-1, 0);
        repeat (100) step();
        @(negedge clk);
        check("tmo_flag",  32'(err_timeout), 32'(TMO_EN));
        check("tmo_busy",  32'(busy), 32'(!TMO_EN));
        check("tmo_fdone", 32'(n_fdone), 32'(TMO_EN));
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
